// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles, one full-subtractor cell
// built from two half-subtractor stages and a registered borrow.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             load, shift_en, last_bit;
  logic             x, y, d1, b1, d, b2, borrow_d;

  // Full-subtractor cell: two half-subtractors plus an OR on the borrows
  always_comb begin
    x        = a_sr[0];
    y        = b_sr[0];
    d1       = x ^ y;
    b1       = ~x & y;
    d        = d1 ^ borrow_q;
    b2       = ~d1 & borrow_q;
    borrow_d = b1 | b2;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    last_bit = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shift registers, bit counter and borrow flop
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      a_sr     <= a;
      b_sr     <= b;
      cnt      <= '0;
      borrow_q <= 1'b0;
    end else if (shift_en) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= {d, res_sr[WIDTH-1:1]};
      cnt      <= cnt + CW'(1);
      borrow_q <= borrow_d;
    end
  end

  // Results publish only when leaving DONE, so they hold through the next computation
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      busy <= (state_d == SHIFT);
      done <= (state == DONE);
      if (state == DONE) begin
        diff       <= res_sr;
        borrow_out <= borrow_q;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;
  int n_done   = 0;

  logic [W-1:0] exp_diff;
  logic         exp_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) n_done <= n_done + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted operation; inj >= 0 pulses a foreign start at that many edges after acceptance
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
    logic [W-1:0] nd;
    logic         nb;
    nd = W'({1'b0, x} - {1'b0, y});
    nb = (x < y);
    a = x; b = y; start = 1'b1;
    tick();
    n_accept++;
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    for (int j = 0; j <= int'(W) + 1; j++) begin
      check("busy", 32'(busy), 32'(j < int'(W)));
      check("done", 32'(done), 32'(j == int'(W) + 1));
      if (j <= int'(W)) begin
        check("diff_hold", 32'(diff), 32'(exp_diff));
        check("borrow_hold", 32'(borrow_out), 32'(exp_borrow));
      end else begin
        check("diff", 32'(diff), 32'(nd));
        check("borrow", 32'(borrow_out), 32'(nb));
      end
      if (j == inj) begin
        start = 1'b1; a = 8'h00; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (j < int'(W) + 1) tick();
    end
    start = 1'b0;
    exp_diff   = nd;
    exp_borrow = nb;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    exp_diff = '0; exp_borrow = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow_out), 32'd0);
      tick();
    end

    run_op(8'h05, 8'h03, -1);
    run_op(8'h03, 8'h05, -1);
    run_op(8'h00, 8'h00, -1);
    run_op(8'hFF, 8'h01, -1);
    run_op(8'h00, 8'hFF, -1);
    run_op(8'h10, 8'h01, 3);
    tick();
    check("retain_diff", 32'(diff), 32'h0F);
    check("retain_done", 32'(done), 32'd0);

    // Reset mid-operation discards the partial result
    a = 8'h80; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    for (int i = 0; i < int'(W) + 3; i++) begin
      check("abort_nodone", 32'(done), 32'd0);
      tick();
    end
    exp_diff = '0; exp_borrow = 1'b0;
    run_op(8'h80, 8'h01, -1);
    check("fresh_diff", 32'(diff), 32'h7F);

    for (int i = 0; i < 200; i++) begin
      int inj;
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
      run_op(W'($urandom), W'($urandom), inj);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    check("done_count", 32'(n_done), 32'(n_accept));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
